gshare_update_ctrl: RTL and testbench

//   Sequencer for the gshare branch predictor's BHT write port. After reset, or on request, it sweeps

---
 rtl/gshare_update_ctrl_if.sv | 35 +++
 rtl/gshare_update_ctrl.sv | 119 +++++++++++
 tb/tb_gshare_update_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gshare_update_ctrl_if.sv
// Bundle of the gshare BHT update sequencer's handshake, BHT-port and status signals.
// The master side is the pipeline plus BHT array; the slave side is the sequencer.
interface gshare_update_ctrl_if #(
  parameter int unsigned PATTERN_WIDTH = 4,
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned DEPTH         = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                     init_req;
  logic                     stall;
  logic                     upd_valid;
  logic                     upd_ready;
  logic [7:0]               upd_pc;
  logic [PATTERN_WIDTH-1:0] upd_pattern;
  logic                     upd_taken;
  logic [PATTERN_WIDTH-1:0] bht_raddr;
  logic [WIDTH-1:0]         bht_rdata;
  logic                     bht_we;
  logic [PATTERN_WIDTH-1:0] bht_waddr;
  logic [WIDTH-1:0]         bht_wdata;
  logic                     hist_clear;
  logic                     pred_valid;
  logic [CNT_W-1:0]         count;

  modport master (
    output init_req, stall, upd_valid, upd_pc, upd_pattern, upd_taken, bht_rdata,
    input  upd_ready, bht_raddr, bht_we, bht_waddr, bht_wdata, hist_clear, pred_valid, count
  );

  modport slave (
    input  init_req, stall, upd_valid, upd_pc, upd_pattern, upd_taken, bht_rdata,
    output upd_ready, bht_raddr, bht_we, bht_waddr, bht_wdata, hist_clear, pred_valid, count
  );
endinterface

// File: rtl/gshare_update_ctrl.sv
// gshare BHT write-port sequencer: init sweep to INIT_VAL, then FIFO-buffered
// read-modify-write of saturating counters at (pc ^ pattern).
module gshare_update_ctrl #(
  parameter int unsigned           PATTERN_WIDTH = 4,
  parameter int unsigned           WIDTH         = 2,
  parameter int unsigned           DEPTH         = 4,
  parameter logic [WIDTH-1:0]      INIT_VAL      = WIDTH'(1)
) (
  input  logic                     clk,
  input  logic                     reset,
  gshare_update_ctrl_if.slave      upd_if
);
  localparam int unsigned ENTRIES = 2 ** PATTERN_WIDTH;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W   = PATTERN_WIDTH + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [PATTERN_WIDTH-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [ENT_W-1:0]         mem_q [DEPTH];

  logic                     full, empty, in_run, push, pop;
  logic [ENT_W-1:0]         head_ent;
  logic [PATTERN_WIDTH-1:0] head_addr;
  logic                     bht_we_c;
  logic [PATTERN_WIDTH-1:0] bht_addr_c;
  logic [WIDTH-1:0]         bht_wdata_c;
  logic                     unused_pc_hi;

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] val, input logic taken);
    if (taken) return (&val) ? val : val + WIDTH'(1);
    else       return (val == '0) ? val : val - WIDTH'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_run    = (state_q == ST_RUN) && !reset;
  assign push      = in_run && upd_if.upd_valid && !full && !upd_if.init_req;
  assign pop       = in_run && !empty && !upd_if.stall && !upd_if.init_req;
  assign head_ent  = mem_q[head_q];
  assign head_addr = head_ent[ENT_W-1:1];

  // Only the low PC bits participate in the index hash.
  assign unused_pc_hi = &{1'b0, upd_if.upd_pc[7:PATTERN_WIDTH]};

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    bht_we_c    = 1'b0;
    bht_addr_c  = head_addr;
    bht_wdata_c = sat(upd_if.bht_rdata, head_ent[0]);
    case (state_q)
      ST_INIT: begin
        if (!reset) begin
          bht_we_c    = 1'b1;
          bht_addr_c  = sweep_q;
          bht_wdata_c = INIT_VAL;
          sweep_d     = sweep_q + PATTERN_WIDTH'(1);
          if (sweep_q == PATTERN_WIDTH'(ENTRIES - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (upd_if.init_req) begin
          // Re-init request discards all pending updates.
          state_d = ST_INIT;
          sweep_d = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          bht_we_c = pop;
          if (pop)  head_d = head_q + PTR_W'(1);
          if (push) tail_d = tail_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {upd_if.upd_pc[PATTERN_WIDTH-1:0] ^ upd_if.upd_pattern, upd_if.upd_taken};
  end

  assign upd_if.bht_we     = bht_we_c;
  assign upd_if.bht_raddr  = bht_addr_c;
  assign upd_if.bht_waddr  = bht_addr_c;
  assign upd_if.bht_wdata  = bht_wdata_c;
  assign upd_if.upd_ready  = in_run && !full && !upd_if.init_req;
  assign upd_if.pred_valid = in_run;
  assign upd_if.hist_clear = (state_q == ST_INIT) || reset;
  assign upd_if.count      = reset ? '0 : count_q;
endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Scoreboard bench for gshare_update_ctrl: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_gshare_update_ctrl;
  localparam int unsigned PW = 4;
  localparam int unsigned W  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned N  = 16;
  localparam logic [1:0]  INIT_V = 2'b01;

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [1:0] wdata;
    logic       ready;
    logic       pv;
    logic       hc;
    logic [2:0] cnt;
  } exp_t;

  typedef struct {
    int addr;
    int taken;
  } upd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gshare_update_ctrl_if #(.PATTERN_WIDTH(PW), .WIDTH(W), .DEPTH(D)) bus ();

  gshare_update_ctrl #(.PATTERN_WIDTH(PW), .WIDTH(W), .DEPTH(D), .INIT_VAL(INIT_V)) dut (
    .clk    (clk),
    .reset  (reset),
    .upd_if (bus)
  );

  // Behavioural BHT array driven by the DUT's write port.
  logic [1:0] bht_arr [N];
  assign bus.bht_rdata = bht_arr[bus.bht_raddr];
  always @(posedge clk) if (bus.bht_we === 1'b1) bht_arr[bus.bht_waddr] <= bus.bht_wdata;

  exp_t exp_q [$];
  upd_t m_fifo [$];
  int   ref_bht [N];
  bit   m_run;
  int   m_sweep;
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    else n_pass++;
  endtask

  function automatic int clamp_step(input int val, input int taken);
    int r;
    r = val + (taken != 0 ? 1 : -1);
    if (r < 0) r = 0;
    if (r > 3) r = 3;
    return r;
  endfunction

  // One clock cycle: drive inputs, record expected outputs, advance the model.
  task automatic cycle(input bit r, input bit ir, input bit st, input bit v,
                       input logic [7:0] pc, input logic [3:0] pat, input bit t);
    exp_t e;
    upd_t u;
    bit   do_pop;
    @(posedge clk);
    #1;
    reset           = r;
    bus.init_req    = ir;
    bus.stall       = st;
    bus.upd_valid   = v;
    bus.upd_pc      = pc;
    bus.upd_pattern = pat;
    bus.upd_taken   = t;
    e = '{we: 1'b0, waddr: 4'h0, wdata: 2'b00, ready: 1'b0, pv: 1'b0, hc: 1'b1, cnt: 3'd0};
    if (r) begin
      m_run   = 1'b0;
      m_sweep = 0;
      m_fifo.delete();
    end else if (!m_run) begin
      e.we    = 1'b1;
      e.waddr = 4'(m_sweep);
      e.wdata = INIT_V;
      ref_bht[m_sweep] = int'(INIT_V);
      m_sweep++;
      if (m_sweep == N) begin
        m_run   = 1'b1;
        m_sweep = 0;
      end
    end else begin
      e.pv    = 1'b1;
      e.hc    = 1'b0;
      e.cnt   = 3'(m_fifo.size());
      e.ready = (m_fifo.size() < D) && !ir;
      if (ir) begin
        m_fifo.delete();
        m_run   = 1'b0;
        m_sweep = 0;
      end else begin
        do_pop = (m_fifo.size() > 0) && !st;
        if (do_pop) begin
          u       = m_fifo.pop_front();
          e.we    = 1'b1;
          e.waddr = 4'(u.addr);
          ref_bht[u.addr] = clamp_step(ref_bht[u.addr], u.taken);
          e.wdata = 2'(ref_bht[u.addr]);
        end
        if (v && e.ready) begin
          u.addr  = int'(pc % 16) ^ int'(pat);
          u.taken = int'(t);
          m_fifo.push_back(u);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bht_we",     32'(bus.bht_we),     32'(e.we));
      check("upd_ready",  32'(bus.upd_ready),  32'(e.ready));
      check("pred_valid", 32'(bus.pred_valid), 32'(e.pv));
      check("hist_clear", 32'(bus.hist_clear), 32'(e.hc));
      check("count",      32'(bus.count),      32'(e.cnt));
      if (e.we) begin
        check("bht_waddr", 32'(bus.bht_waddr), 32'(e.waddr));
        check("bht_raddr", 32'(bus.bht_raddr), 32'(e.waddr));
        check("bht_wdata", 32'(bus.bht_wdata), 32'(e.wdata));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_run   = 1'b0;
    m_sweep = 0;
    for (int i = 0; i < N; i++) begin
      bht_arr[i] = 2'($urandom);
      ref_bht[i] = 0;
    end
    reset           = 1'b1;
    bus.init_req    = 1'b0;
    bus.stall       = 1'b0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = 8'h00;
    bus.upd_pattern = 4'h0;
    bus.upd_taken   = 1'b0;

    // Reset, then the initial 16-entry sweep.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    idle(20);

    // Single update: pc 0x13 ^ pattern 0101 -> address 6, 01 -> 10.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 4'b0101, 1'b1);
    idle(3);

    // Saturation at both ends on one address.
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 4'h0, 1'b1);
    idle(3);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 4'h0, 1'b0);
    idle(3);

    // Stalled fill to full, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 4'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 4'h0, 1'b1);
    idle(6);

    // Three pending entries discarded by init_req.
    for (int i = 5; i <= 7; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 4'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 4'h0, 1'b1);

    // Reset asserted at sweep index 7 for two cycles.
    idle(7);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    idle(20);

    // Randomised traffic with stalls, rare re-inits and rare resets.
    for (int i = 0; i < 800; i++) begin
      bit         r, ir, st, v, t;
      logic [7:0] pc;
      logic [3:0] pat;
      r   = ($urandom_range(0, 299) == 0);
      ir  = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 2) != 0);
      t   = 1'($urandom);
      pc  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      pat = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cycle(r, ir, st, v, pc, pat, t);
    end
    idle(20);

    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
